// File: rtl/uart_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_frame : 8N1 UART receiver with mid-bit sampling, valid strobe and   |
// |                 framing-error strobe, break-safe recovery.                  |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50,
  input  logic       Reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_sample;
  logic            w_valid;
  logic            w_ferr;
  logic            w_cnt_last;
  logic            w_cnt_half;

  assign w_cnt_last = (r_cnt == c_last);
  assign w_cnt_half = (r_cnt == c_half);
  assign busy       = (r_state != S_IDLE);

  // Two-flop synchroniser, preset high so reset looks like an idle line.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_valid  = 1'b0;
    w_ferr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) w_next = S_START;
      end
      S_START: begin
        if (w_cnt_half) w_next = r_sync2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_sample = 1'b1;
          if (r_bit == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
          if (r_sync2) begin
            w_valid = 1'b1;
            w_next  = S_IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_next  = S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        // Hold here through a break until the line goes idle again.
        if (r_sync2) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= 3'd0;
      r_shift   <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      valid     <= w_valid;
      frame_err <= w_ferr;

      if ((w_next != r_state) || (r_state == S_IDLE) ||
          (r_state == S_RECOVER) || w_cnt_last)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + c_one;

      if (r_state == S_START)
        r_bit <= 3'd0;
      else if (w_sample)
        r_bit <= r_bit + 3'd1;

      if (w_sample) r_shift[r_bit] <= r_sync2;
      if (w_valid)  data <= r_shift;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_frame : self-checking bench for uart_rx_frame (8N1 receiver).    |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_uart_rx_frame;

  localparam int CPB  = 434;
  localparam int CPB2 = 16;

  logic       CLOCK_50 = 1'b0;
  logic       Reset_n  = 1'b0;
  logic       rx       = 1'b1;
  logic       rx2      = 1'b1;
  logic [7:0] data, data2;
  logic       valid, valid2, frame_err, frame_err2, busy, busy2;

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50(CLOCK_50), .Reset_n(Reset_n), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  uart_rx_frame #(.CLKS_PER_BIT(CPB2)) dut2 (
    .CLOCK_50(CLOCK_50), .Reset_n(Reset_n), .rx(rx2),
    .data(data2), .valid(valid2), .frame_err(frame_err2), .busy(busy2)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Observed strobes, sampled on the falling edge.
  int         nv = 0, nf = 0, overlap = 0, nv2 = 0, nf2 = 0;
  logic [7:0] got_q[$];
  int         vt_q[$];
  logic [7:0] got2_q[$];
  logic [7:0] data_at_ferr = 8'h00;
  logic       prev_valid = 1'b0, prev_ferr = 1'b0;

  always @(negedge CLOCK_50) begin
    if (valid) begin got_q.push_back(data); vt_q.push_back(cyc); nv++; end
    if (frame_err) begin nf++; data_at_ferr = data; end
    if ((valid && frame_err) || (valid && prev_ferr) || (frame_err && prev_valid)) overlap++;
    prev_valid = valid;
    prev_ferr  = frame_err;
    if (valid2) begin got2_q.push_back(data2); nv2++; end
    if (frame_err2) nf2++;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_mon();
    nv = 0; nf = 0; got_q.delete(); vt_q.delete();
  endtask

  // Reference frame: start bit, 8 data bits LSB first, stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      hold(CPB);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    hold(5);
    total++; if ({data, valid, frame_err, busy} !== 11'h000)
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b busy=%b, want all 0", data, valid, frame_err, busy);
    else passed++;
    Reset_n = 1'b1;
    hold(5);
  endtask

  task automatic test_basic();
    logic [7:0] b;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    hold(CPB);
    total++; if (nv !== 1) $display("FAIL basic_valid_count: got %0d want 1", nv); else passed++;
    total++; if (data !== 8'hA5) $display("FAIL basic_data: got %h want a5", data); else passed++;
    total++; if (nf !== 0) $display("FAIL basic_ferr: got %0d want 0", nf); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy); else passed++;
    b = 8'($urandom);
    clear_mon();
    send_frame(b, 1'b1);
    total++; if (nv !== 1 || data !== b)
      $display("FAIL basic_random: got n=%0d data=%h want n=1 data=%h", nv, data, b);
    else passed++;
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0; hold(100);
    rx = 1'b1; hold(130);
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy); else passed++;
    total++; if (nv !== 0 || nf !== 0)
      $display("FAIL glitch_strobes: got v=%0d fe=%0d want 0/0", nv, nf);
    else passed++;
    send_frame(8'h3C, 1'b1);
    total++; if (nv !== 1 || data !== 8'h3C)
      $display("FAIL glitch_next_frame: got n=%0d data=%h want n=1 data=3c", nv, data);
    else passed++;
  endtask

  task automatic test_frame_err();
    logic [7:0] prev;
    prev = data;
    clear_mon();
    send_frame(8'h5A, 1'b0);
    hold(2000);
    total++; if (nf !== 1) $display("FAIL ferr_count: got %0d want 1", nf); else passed++;
    total++; if (data_at_ferr !== prev || data !== prev)
      $display("FAIL ferr_data_hold: got %h/%h want %h", data_at_ferr, data, prev);
    else passed++;
    total++; if (nv !== 0) $display("FAIL ferr_no_valid: got %0d want 0", nv); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL ferr_busy_break: got %b want 1", busy); else passed++;
    rx = 1'b1; hold(CPB);
    send_frame(8'h81, 1'b1);
    total++; if (nv !== 1 || data !== 8'h81 || nf !== 1)
      $display("FAIL ferr_recover: got n=%0d fe=%0d data=%h want 1/1/81", nv, nf, data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(CPB);
    total++; if (got_q.size() != 2 || got_q[0] !== 8'h00 || got_q[1] !== 8'hFF)
      $display("FAIL b2b_data: got n=%0d want 2 bytes 00 ff", got_q.size());
    else passed++;
    gap = (vt_q.size() == 2) ? vt_q[1] - vt_q[0] : -1;
    total++; if (gap < 10*CPB - 2 || gap > 10*CPB + 2)
      $display("FAIL b2b_spacing: got %0d want %0d", gap, 10*CPB);
    else passed++;
    total++; if (overlap !== 0) $display("FAIL strobe_exclusive: got %0d want 0", overlap); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'($urandom);
    clear_mon();
    rx = 1'b0; hold(CPB);
    for (int i = 0; i < 4; i++) begin rx = b[i]; hold(CPB); end
    rx = b[4]; hold(CPB/2);
    Reset_n = 1'b0;
    #1;
    total++; if ({data, valid, frame_err, busy} !== 11'h000)
      $display("FAIL midreset_outputs: got data=%h v=%b fe=%b busy=%b, want all 0", data, valid, frame_err, busy);
    else passed++;
    hold(5);
    rx = 1'b1; hold(5);
    Reset_n = 1'b1;
    hold(2*CPB);
    total++; if (nv !== 0 || nf !== 0)
      $display("FAIL midreset_no_strobe: got v=%0d fe=%0d want 0/0", nv, nf);
    else passed++;
    send_frame(8'h7E, 1'b1);
    total++; if (nv !== 1 || data !== 8'h7E)
      $display("FAIL midreset_next: got n=%0d data=%h want 1/7e", nv, data);
    else passed++;
  endtask

  // Each frame is 160 cycles; every internal bit edge moves by -3..+3 cycles.
  task automatic test_jitter();
    logic [7:0] exp_q[$];
    logic [9:0] bits;
    int         bnd[11];
    int         k;
    logic [7:0] b;
    nv2 = 0; nf2 = 0; got2_q.delete();
    for (int f = 0; f < 256; f++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bits = {1'b1, b, 1'b0};
      bnd[0]  = 0;
      bnd[10] = 10*CPB2;
      for (int i = 1; i < 10; i++) bnd[i] = i*CPB2 + int'($urandom_range(0, 6)) - 3;
      k = 0;
      for (int t = 0; t < 10*CPB2; t++) begin
        while (t >= bnd[k+1]) k++;
        rx2 = bits[k];
        hold(1);
      end
    end
    rx2 = 1'b1;
    hold(4*CPB2);
    total++; if (nv2 !== 256) $display("FAIL jitter_count: got %0d want 256", nv2); else passed++;
    total++; if (nf2 !== 0) $display("FAIL jitter_ferr: got %0d want 0", nf2); else passed++;
    for (int i = 0; i < 256; i++) begin
      total++; if (i >= got2_q.size() || got2_q[i] !== exp_q[i])
        $display("FAIL jitter_byte%0d: got %h want %h", i, (i < got2_q.size()) ? got2_q[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    hold(1);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_jitter();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
